// File: rtl/cache_tag_array_flush.sv
// Tag/valid/dirty store for all ways of one cache with registered per-way hit detect
// and a flush engine that writes back dirty lines over WbReq/WbAck, then invalidates.
module cache_tag_array_flush #(
  parameter int NUMWAYS   = 4,
  parameter int NUMLINES  = 128,
  parameter int TAGLEN    = 20,
  parameter int READ_ONLY = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        CacheEn,
  input  logic [$clog2(NUMLINES)-1:0] CacheSet,
  input  logic [TAGLEN-1:0]           Tag,
  input  logic                        SetValid,
  input  logic                        SetDirty,
  input  logic                        ClearDirty,
  input  logic [NUMWAYS-1:0]          VictimWay,
  input  logic                        InvalidateCache,
  input  logic                        FlushStart,
  input  logic                        WbAck,
  output logic [NUMWAYS-1:0]          HitWay,
  output logic                        Hit,
  output logic [NUMWAYS-1:0]          ValidWay,
  output logic                        DirtyVictim,
  output logic [TAGLEN-1:0]           VictimTag,
  output logic                        FlushBusy,
  output logic                        FlushDone,
  output logic                        WbReq,
  output logic [$clog2(NUMLINES)-1:0] WbSet,
  output logic [NUMWAYS-1:0]          WbWay,
  output logic [TAGLEN-1:0]           WbTag,
  output logic [2:0]                  dbg_state
);
  localparam int SETLEN = $clog2(NUMLINES);
  localparam int WAYLEN = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WB, S_NEXT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SETLEN-1:0]   fl_set_q, fl_set_d;
  logic [WAYLEN-1:0]   fl_way_q, fl_way_d;
  logic [NUMWAYS-1:0]  valid_q [NUMLINES];
  logic [NUMWAYS-1:0]  valid_d [NUMLINES];
  logic [NUMWAYS-1:0]  dirty_q [NUMLINES];
  logic [NUMWAYS-1:0]  dirty_d [NUMLINES];
  logic [TAGLEN-1:0]   tag_mem [NUMLINES][NUMWAYS];
  logic [NUMWAYS-1:0]  hit_way_q, hit_way_d, valid_way_q, valid_way_d;
  logic                dirty_victim_q, dirty_victim_d;
  logic [TAGLEN-1:0]   victim_tag_q, victim_tag_d;
  logic [NUMWAYS-1:0]  cur_hit;
  logic [TAGLEN-1:0]   vic_tag;
  logic                vic_dirty;
  logic                access;
  logic                tag_we;

  // Lookup reads the arrays before this edge's update lands, so no bypass.
  always_comb begin
    cur_hit   = '0;
    vic_tag   = '0;
    vic_dirty = 1'b0;
    access    = CacheEn && (state_q == S_IDLE);
    for (int w = 0; w < NUMWAYS; w++) begin
      cur_hit[w] = valid_q[CacheSet][w] && (tag_mem[CacheSet][w] == Tag);
      if (VictimWay[w] && valid_q[CacheSet][w]) begin
        vic_tag   = vic_tag | tag_mem[CacheSet][w];
        vic_dirty = vic_dirty | dirty_q[CacheSet][w];
      end
    end
    hit_way_d      = access ? cur_hit          : hit_way_q;
    valid_way_d    = access ? valid_q[CacheSet] : valid_way_q;
    dirty_victim_d = access ? vic_dirty        : dirty_victim_q;
    victim_tag_d   = access ? vic_tag          : victim_tag_q;
  end

  // WbReq rises in WB and stays high with WbSet/WbWay/WbTag stable until the
  // cycle WbAck is sampled high; WbAck in any other state has no effect.
  always_comb begin
    state_d  = state_q;
    fl_set_d = fl_set_q;
    fl_way_d = fl_way_q;
    tag_we   = 1'b0;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    if (InvalidateCache) begin
      for (int l = 0; l < NUMLINES; l++) begin
        valid_d[l] = '0;
        dirty_d[l] = '0;
      end
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (FlushStart) begin
            state_d  = S_SCAN;
            fl_set_d = '0;
            fl_way_d = '0;
          end else if (CacheEn) begin
            if (SetValid) begin
              tag_we            = 1'b1;
              valid_d[CacheSet] = valid_q[CacheSet] | VictimWay;
              if (SetDirty && READ_ONLY == 0) dirty_d[CacheSet] = dirty_q[CacheSet] | VictimWay;
              else                            dirty_d[CacheSet] = dirty_q[CacheSet] & ~VictimWay;
            end else if (SetDirty && READ_ONLY == 0) begin
              dirty_d[CacheSet] = dirty_q[CacheSet] | cur_hit;
            end else if (ClearDirty && READ_ONLY == 0) begin
              dirty_d[CacheSet] = dirty_q[CacheSet] & ~cur_hit;
            end
          end
        end
        S_SCAN: begin
          if (valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q] && READ_ONLY == 0) begin
            state_d = S_WB;
          end else begin
            valid_d[fl_set_q][fl_way_q] = 1'b0;
            state_d = S_NEXT;
          end
        end
        S_WB: begin
          if (WbAck) begin
            valid_d[fl_set_q][fl_way_q] = 1'b0;
            dirty_d[fl_set_q][fl_way_q] = 1'b0;
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (fl_set_q == SETLEN'(NUMLINES - 1) && fl_way_q == WAYLEN'(NUMWAYS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            if (fl_way_q == WAYLEN'(NUMWAYS - 1)) begin
              fl_way_d = '0;
              fl_set_d = fl_set_q + SETLEN'(1);
            end else begin
              fl_way_d = fl_way_q + WAYLEN'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      fl_set_q       <= '0;
      fl_way_q       <= '0;
      hit_way_q      <= '0;
      valid_way_q    <= '0;
      dirty_victim_q <= 1'b0;
      victim_tag_q   <= '0;
      for (int l = 0; l < NUMLINES; l++) begin
        valid_q[l] <= '0;
        dirty_q[l] <= '0;
      end
    end else begin
      state_q        <= state_d;
      fl_set_q       <= fl_set_d;
      fl_way_q       <= fl_way_d;
      hit_way_q      <= hit_way_d;
      valid_way_q    <= valid_way_d;
      dirty_victim_q <= dirty_victim_d;
      victim_tag_q   <= victim_tag_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      for (int w = 0; w < NUMWAYS; w++) begin
        if (VictimWay[w]) tag_mem[CacheSet][w] <= Tag;
      end
    end
  end

  assign HitWay      = hit_way_q;
  assign Hit         = |hit_way_q;
  assign ValidWay    = valid_way_q;
  assign DirtyVictim = dirty_victim_q;
  assign VictimTag   = victim_tag_q;
  assign FlushBusy   = (state_q != S_IDLE);
  assign FlushDone   = (state_q == S_DONE);
  assign WbReq       = (state_q == S_WB);
  assign WbSet       = WbReq ? fl_set_q : '0;
  assign WbWay       = WbReq ? (NUMWAYS'(1) << fl_way_q) : '0;
  assign WbTag       = WbReq ? tag_mem[fl_set_q][fl_way_q] : '0;
  assign dbg_state   = state_q;

  hit_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(hit_way_q));
endmodule

// File: tb/tb_cache_tag_array_flush.sv
// Scenario bench for cache_tag_array_flush: lookups, dirty tracking, flush sweep,
// abort by invalidate, and a read-only instance flushed on its own start pulse.
module tb_cache_tag_array_flush;
  logic        clk = 1'b0;
  logic        reset;
  logic        cache_en, set_valid, set_dirty, clear_dirty;
  logic [6:0]  cache_set;
  logic [19:0] tag;
  logic [3:0]  victim_way;
  logic        invalidate_cache, flush_start, ro_flush_start, wb_ack;

  logic [3:0]  hit_way, valid_way, wb_way;
  logic        hit, dirty_victim, flush_busy, flush_done, wb_req;
  logic [19:0] victim_tag, wb_tag;
  logic [6:0]  wb_set;
  logic [2:0]  dbg_state;

  logic [3:0]  ro_hit_way, ro_valid_way, ro_wb_way;
  logic        ro_hit, ro_dirty_victim, ro_flush_busy, ro_flush_done, ro_wb_req;
  logic [19:0] ro_victim_tag, ro_wb_tag;
  logic [6:0]  ro_wb_set;
  logic [2:0]  ro_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];  // {hit_way, valid_way, dirty_victim, victim_tag}
  logic [30:0] wb_q[$];   // {wb_set, wb_way, wb_tag}

  always #5 clk = ~clk;

  cache_tag_array_flush u_dut (
    .clk(clk), .reset(reset), .CacheEn(cache_en), .CacheSet(cache_set), .Tag(tag),
    .SetValid(set_valid), .SetDirty(set_dirty), .ClearDirty(clear_dirty),
    .VictimWay(victim_way), .InvalidateCache(invalidate_cache), .FlushStart(flush_start),
    .WbAck(wb_ack), .HitWay(hit_way), .Hit(hit), .ValidWay(valid_way),
    .DirtyVictim(dirty_victim), .VictimTag(victim_tag), .FlushBusy(flush_busy),
    .FlushDone(flush_done), .WbReq(wb_req), .WbSet(wb_set), .WbWay(wb_way),
    .WbTag(wb_tag), .dbg_state(dbg_state)
  );

  cache_tag_array_flush #(.READ_ONLY(1)) u_ro (
    .clk(clk), .reset(reset), .CacheEn(cache_en), .CacheSet(cache_set), .Tag(tag),
    .SetValid(set_valid), .SetDirty(set_dirty), .ClearDirty(clear_dirty),
    .VictimWay(victim_way), .InvalidateCache(invalidate_cache), .FlushStart(ro_flush_start),
    .WbAck(wb_ack), .HitWay(ro_hit_way), .Hit(ro_hit), .ValidWay(ro_valid_way),
    .DirtyVictim(ro_dirty_victim), .VictimTag(ro_victim_tag), .FlushBusy(ro_flush_busy),
    .FlushDone(ro_flush_done), .WbReq(ro_wb_req), .WbSet(ro_wb_set), .WbWay(ro_wb_way),
    .WbTag(ro_wb_tag), .dbg_state(ro_dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cache_en = 0; cache_set = '0; tag = '0; victim_way = '0;
    set_valid = 0; set_dirty = 0; clear_dirty = 0;
    invalidate_cache = 0; flush_start = 0; ro_flush_start = 0; wb_ack = 0;
  endtask

  // One enabled cycle; when chk is set the registered lookup result is scored.
  task automatic op(input logic [6:0] s, input logic [19:0] t, input logic [3:0] v,
                    input logic sv, input logic sd, input logic cd, input logic chk,
                    input logic [3:0] e_hit, input logic [3:0] e_valid,
                    input logic e_dv, input logic [19:0] e_vtag);
    logic [28:0] got, e;
    cache_en = 1; cache_set = s; tag = t; victim_way = v;
    set_valid = sv; set_dirty = sd; clear_dirty = cd;
    if (chk) exp_q.push_back({e_hit, e_valid, e_dv, e_vtag});
    step();
    cache_en = 0; set_valid = 0; set_dirty = 0; clear_dirty = 0;
    if (chk) begin
      got = {hit_way, valid_way, dirty_victim, victim_tag};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL lookup set=%0d tag=%h: got %h expected %h", s, t, got, e);
      end
      checks++;
      if (hit !== (|e[28:25])) begin
        errors++;
        $display("FAIL hit set=%0d: got %b expected %b", s, hit, |e[28:25]);
      end
    end
  endtask

  task automatic start_flush_wait_wb(input logic [6:0] e_set);
    int n;
    flush_start = 1;
    step();
    flush_start = 0;
    n = 0;
    while (!wb_req && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (!wb_req || wb_set !== e_set) begin
      errors++;
      $display("FAIL wb_wait: wb_req=%b wb_set=%0d expected req at set %0d", wb_req, wb_set, e_set);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    step(); step();
    checks++;
    if ({hit_way, hit, valid_way, dirty_victim, victim_tag, flush_busy, flush_done,
         wb_req, wb_set, wb_way, wb_tag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero (busy=%b req=%b valid=%b)",
               flush_busy, wb_req, valid_way);
    end
    reset = 0;
    step();
    op(7'd9, 20'h99999, 4'b0001, 1, 1, 0, 0, '0, '0, 0, '0);
    op(7'd9, 20'h99999, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001, 1, 20'h99999);
    start_flush_wait_wb(7'd9);
    #2 reset = 1;
    #1;
    checks++;
    if (wb_req !== 0 || flush_busy !== 0 || valid_way !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_flush: req=%b busy=%b valid=%b expected 0 0 0000",
               wb_req, flush_busy, valid_way);
    end
    step();
    reset = 0;
    step();
  endtask

  task automatic test_hit_detect();
    op(7'd5, 20'hABCDE, 4'b0100, 1, 0, 0, 0, '0, '0, 0, '0);
    op(7'd5, 20'hABCDE, 4'b0100, 0, 0, 0, 1, 4'b0100, 4'b0100, 0, 20'hABCDE);
    op(7'd5, 20'hABCDF, 4'b0100, 0, 0, 0, 1, 4'b0000, 4'b0100, 0, 20'hABCDE);
    op(7'd5, 20'hABCDE, 4'b0001, 0, 0, 0, 1, 4'b0100, 4'b0100, 0, 20'h00000);
  endtask

  task automatic test_dirty();
    op(7'd7, 20'h12345, 4'b0001, 1, 1, 0, 0, '0, '0, 0, '0);
    op(7'd7, 20'h12345, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001, 1, 20'h12345);
    op(7'd7, 20'h12345, 4'b0001, 0, 0, 1, 1, 4'b0001, 4'b0001, 1, 20'h12345);
    op(7'd7, 20'h12345, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001, 0, 20'h12345);
    op(7'd7, 20'h54321, 4'b0001, 0, 1, 0, 1, 4'b0000, 4'b0001, 0, 20'h12345);
    op(7'd7, 20'h12345, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001, 0, 20'h12345);
  endtask

  task automatic test_flush_writeback();
    int n_req, n_done, hold;
    logic in_req;
    logic [30:0] cur, e;
    op(7'd3,   20'h00333, 4'b0010, 1, 1, 0, 0, '0, '0, 0, '0);
    op(7'd127, 20'h7F7F7, 4'b1000, 1, 1, 0, 0, '0, '0, 0, '0);
    wb_q.push_back({7'd3,   4'b0010, 20'h00333});
    wb_q.push_back({7'd127, 4'b1000, 20'h7F7F7});
    n_req = 0; n_done = 0; hold = 0; in_req = 0; cur = '0;
    flush_start = 1;
    step();
    flush_start = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!flush_busy) break;
      if (wb_req) begin
        if (!in_req) begin
          in_req = 1; hold = 0; n_req++;
          cur = {wb_set, wb_way, wb_tag};
          checks++;
          if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_extra: unexpected request %h", cur);
          end else begin
            e = wb_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL wb_entry: got %h expected %h", cur, e);
            end
          end
        end else begin
          checks++;
          if ({wb_set, wb_way, wb_tag} !== cur) begin
            errors++;
            $display("FAIL wb_stable: got %h held %h", {wb_set, wb_way, wb_tag}, cur);
          end
        end
        hold++;
        wb_ack = (hold == 3);
      end else begin
        in_req = 0;
        wb_ack = 0;
      end
      if (flush_done) n_done++;
      step();
    end
    wb_ack = 0;
    checks++;
    if (n_req !== 2 || n_done !== 1 || wb_q.size() !== 0 || flush_busy !== 0) begin
      errors++;
      $display("FAIL flush_summary: reqs=%0d done=%0d left=%0d busy=%b expected 2 1 0 0",
               n_req, n_done, wb_q.size(), flush_busy);
    end
    op(7'd3,   20'h00333, 4'b0010, 0, 0, 0, 1, '0, '0, 0, '0);
    op(7'd127, 20'h7F7F7, 4'b1000, 0, 0, 0, 1, '0, '0, 0, '0);
    op(7'd5,   20'hABCDE, 4'b0100, 0, 0, 0, 1, '0, '0, 0, '0);
    op(7'd7,   20'h12345, 4'b0001, 0, 0, 0, 1, '0, '0, 0, '0);
  endtask

  task automatic test_clean_flush();
    int n;
    flush_start = 1;
    step();
    flush_start = 0;
    n = 1;
    while (!flush_done && n < 2000) begin
      if (n == 1000) begin
        cache_en = 1; cache_set = 7'd11; tag = 20'h11111; victim_way = 4'b0010; set_valid = 1;
      end else begin
        cache_en = 0; set_valid = 0;
      end
      step();
      n++;
    end
    cache_en = 0; set_valid = 0;
    checks++;
    if (n !== 1025) begin
      errors++;
      $display("FAIL clean_flush_len: got %0d cycles expected 1025", n);
    end
    step();
    op(7'd11, 20'h11111, 4'b0010, 0, 0, 0, 1, '0, '0, 0, '0);
  endtask

  task automatic test_invalidate_abort();
    int done_seen;
    op(7'd2, 20'h22222, 4'b0010, 1, 1, 0, 0, '0, '0, 0, '0);
    op(7'd4, 20'h44444, 4'b0001, 1, 0, 0, 0, '0, '0, 0, '0);
    start_flush_wait_wb(7'd2);
    invalidate_cache = 1;
    step();
    invalidate_cache = 0;
    checks++;
    if (wb_req !== 0 || flush_busy !== 0) begin
      errors++;
      $display("FAIL abort: req=%b busy=%b expected 0 0", wb_req, flush_busy);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (flush_done) done_seen++;
      step();
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses expected 0", done_seen);
    end
    op(7'd2, 20'h22222, 4'b0010, 0, 0, 0, 1, '0, '0, 0, '0);
    op(7'd4, 20'h44444, 4'b0001, 0, 0, 0, 1, '0, '0, 0, '0);
  endtask

  task automatic test_read_only();
    int n, wb_seen;
    op(7'd6, 20'h66666, 4'b0001, 1, 1, 0, 0, '0, '0, 0, '0);
    op(7'd6, 20'h66666, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001, 1, 20'h66666);
    checks++;
    if (ro_hit_way !== 4'b0001 || ro_dirty_victim !== 0) begin
      errors++;
      $display("FAIL ro_lookup: hit=%b dv=%b expected 0001 0", ro_hit_way, ro_dirty_victim);
    end
    ro_flush_start = 1;
    step();
    ro_flush_start = 0;
    n = 1; wb_seen = 0;
    while (!ro_flush_done && n < 2000) begin
      if (ro_wb_req) wb_seen++;
      step();
      n++;
    end
    checks++;
    if (wb_seen !== 0 || n !== 1025) begin
      errors++;
      $display("FAIL ro_flush: wb cycles=%0d len=%0d expected 0 1025", wb_seen, n);
    end
    step();
    op(7'd6, 20'h66666, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001, 1, 20'h66666);
    checks++;
    if (ro_valid_way !== 4'b0000) begin
      errors++;
      $display("FAIL ro_invalidated: valid=%b expected 0000", ro_valid_way);
    end
  endtask

  initial begin
    test_reset();
    test_hit_detect();
    test_dirty();
    test_flush_writeback();
    test_clean_flush();
    test_invalidate_abort();
    test_read_only();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
